roic_spi_responder: RTL and testbench

Synthesizable SPI responder for the TI ROIC register interface. It receives 24-bit write frames from the ROIC SPI master (SCLK/SDATA/SEN) into a local register file and, in read mode, returns register contents on SDOUT. It serves as an on-FPGA ROIC emulator for loopback bring-up and as the verification counterpart of the ROIC SPI master. It sits on the 20 MHz timing-generator clock domain and oversamples the SPI pins.

---
 rtl/roic_spi_pkg.sv | 14 +
 rtl/roic_spi_edge_sync.sv | 31 +++
 rtl/roic_spi_responder.sv | 172 +++++++++++++++++
 tb/tb_roic_spi_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/roic_spi_pkg.sv
// rtl/roic_spi_pkg.sv - shared frame constants and FSM state type for the ROIC SPI responder
package roic_spi_pkg;
  localparam int         FRAME_BITS   = 24;
  localparam int         ADDR_BITS    = 8;
  localparam int         DATA_BITS    = 16;
  localparam logic [7:0] RD_CTRL_ADDR = 8'h00;
  localparam int         RD_CTRL_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/roic_spi_edge_sync.sv
// rtl/roic_spi_edge_sync.sv - 2-FF synchronizer with history flop and rise/fall decode
module roic_spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_hist <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_hist;
  assign o_fall  = ~r_sync & r_hist;
endmodule

// File: rtl/roic_spi_responder.sv
// rtl/roic_spi_responder.sv - ROIC SPI responder: oversampled 24-bit frames into a local register file
// Readback on spi_sdout and read-mode write gating exist only with ROIC_SPI_RSP_READBACK_EN defined.
module roic_spi_responder
  import roic_spi_pkg::*;
#(
  parameter int REG_ADDR_W = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_spi_sclk,
  input  logic                 i_spi_sdata,
  input  logic                 i_spi_sen,
  output logic                 o_spi_sdout,
  output logic                 o_wr_valid,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [DATA_BITS-1:0] o_wr_data,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic                 o_read_mode
);
  localparam int         NUM_REGS = 2**REG_ADDR_W;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_sen_level, w_sen_rise, w_sen_fall;

  roic_spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_spi_sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  roic_spi_edge_sync #(.RESET_VAL(1'b1)) u_sen_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_spi_sen),
    .o_level(w_sen_level), .o_rise(w_sen_rise), .o_fall(w_sen_fall)
  );

  logic w_unused_sclk;
  assign w_unused_sclk = w_sclk_level ^ w_sclk_fall;

  logic                 r_sd_d1, r_sd_d2;
  logic [1:0]           r_vld;
  logic                 r_armed;
  state_t               r_state;
  logic [4:0]           r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                 r_overrun;
  logic                 r_wr_valid, r_frame_err;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic [DATA_BITS-1:0] r_regs [0:NUM_REGS-1];

  logic [FRAME_BITS-1:0] w_shift_next;
  logic [ADDR_BITS-1:0]  w_cmt_addr;
  logic [DATA_BITS-1:0]  w_cmt_data;
  logic                  w_in_range, w_read_mode, w_rd_gate, w_commit_ok;

  assign w_shift_next = {r_shift[FRAME_BITS-2:0], r_sd_d2};
  assign w_cmt_addr   = r_shift[FRAME_BITS-1:DATA_BITS];
  assign w_cmt_data   = r_shift[DATA_BITS-1:0];
  assign w_in_range   = (w_cmt_addr >> REG_ADDR_W) == '0;
  assign w_read_mode  = r_regs[0][RD_CTRL_BIT];
`ifdef ROIC_SPI_RSP_READBACK_EN
  assign w_rd_gate    = w_read_mode;
`else
  assign w_rd_gate    = 1'b0;
`endif
  assign w_commit_ok  = ~w_rd_gate | (w_cmt_addr == RD_CTRL_ADDR);

  // SEN is only trusted once the synchronizer holds a real sample showing it high,
  // so a SEN held low through reset release never starts a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sd_d1 <= 1'b0;
      r_sd_d2 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sd_d1 <= i_spi_sdata;
      r_sd_d2 <= r_sd_d1;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & w_sen_level);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sen_fall && r_armed) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_sen_rise) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end else if (w_sclk_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == LAST_BIT) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_sen_rise) begin
            r_state <= IDLE;
            if (r_overrun) begin
              r_frame_err <= 1'b1;
            end else if (w_commit_ok) begin
              r_wr_valid <= 1'b1;
              r_wr_addr  <= w_cmt_addr;
              r_wr_data  <= w_cmt_data;
              if (w_in_range) r_regs[w_cmt_addr[REG_ADDR_W-1:0]] <= w_cmt_data;
            end
          end else if (w_sclk_rise) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROIC_SPI_RSP_READBACK_EN
  logic [DATA_BITS-1:0] r_rb;
  logic                 r_rd_active;
  logic [ADDR_BITS-1:0] w_rb_addr;
  logic                 w_in_shift;

  assign w_rb_addr  = w_shift_next[ADDR_BITS-1:0];
  assign w_in_shift = (r_state == SHIFT) && !w_sen_rise;

  // The address completes on the 8th rise, so the lookup uses the incoming bit directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rb        <= '0;
      r_rd_active <= 1'b0;
    end else if (!w_in_shift) begin
      r_rd_active <= 1'b0;
    end else if (w_sclk_rise && r_bit_cnt == 5'd7) begin
      r_rd_active <= w_read_mode;
      r_rb        <= ((w_rb_addr >> REG_ADDR_W) == '0) ? r_regs[w_rb_addr[REG_ADDR_W-1:0]] : '0;
    end else if (w_sclk_fall && r_rd_active && r_bit_cnt <= LAST_BIT) begin
      r_rb <= {r_rb[DATA_BITS-2:0], 1'b0};
    end
  end

  assign o_spi_sdout = r_rd_active & w_read_mode & r_rb[DATA_BITS-1];
`else
  assign o_spi_sdout = 1'b0;
`endif

  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state == SHIFT) || (r_state == HOLD);
  assign o_read_mode = w_read_mode;
endmodule

// File: tb/tb_roic_spi_responder.sv
// tb/tb_roic_spi_responder.sv - scoreboard bench for roic_spi_responder with a frame-level reference model
module tb_roic_spi_responder;
`ifdef ROIC_SPI_RSP_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sclk, sdata, sen;
  logic        o_spi_sdout, o_wr_valid, o_frame_err, o_busy, o_read_mode;
  logic [7:0]  o_wr_addr;
  logic [15:0] o_wr_data;

  always #25 clk = ~clk;

  roic_spi_responder #(.REG_ADDR_W(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_sclk(sclk), .i_spi_sdata(sdata), .i_spi_sen(sen),
    .o_spi_sdout(o_spi_sdout), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_frame_err(o_frame_err), .o_busy(o_busy),
    .o_read_mode(o_read_mode)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          rmode;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_regs [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
    check("event_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clock_bits(input logic [23:0] word, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      sdata = (i < 24) ? word[23-i] : 1'($urandom_range(0, 1));
      tick(4);
      sclk = 1'b1;
      tick(4);
      if (i >= 7 && i <= 22) rd = {rd[14:0], o_spi_sdout};
      sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic send_frame(input logic [23:0] word, input int n, input bit simul);
    logic [7:0]  a;
    logic [15:0] d, exp_rb, rd;
    bit          rmode;
    ev_t         e;
    a      = word[23:16];
    d      = word[15:0];
    rmode  = RB_EN && model_regs[0][1];
    exp_rb = (a < 8'd128) ? model_regs[a[6:0]] : 16'h0000;
    if (n != 24) begin
      e.is_err = 1'b1; e.addr = '0; e.data = '0; e.rmode = 1'b0;
      exp_q.push_back(e);
    end else if (!rmode || a == 8'h00) begin
      if (a < 8'd128) model_regs[a[6:0]] = d;
      e.is_err = 1'b0; e.addr = a; e.data = d; e.rmode = model_regs[0][1];
      exp_q.push_back(e);
    end
    sen = 1'b0;
    tick(4);
    check("busy_in_frame", 32'(o_busy), 32'd1);
    clock_bits(word, n, rd);
    if (simul) begin
      sclk = 1'b1;
      sen  = 1'b1;
      tick(4);
      sclk = 1'b0;
    end else begin
      sen = 1'b1;
    end
    tick(6);
    if (n >= 24) check("sdout_word", 32'(rd), 32'(rmode ? exp_rb : 16'h0000));
    drain();
    check("busy_idle", 32'(o_busy), 32'd0);
    check("read_mode", 32'(o_read_mode), 32'(model_regs[0][1]));
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (o_wr_valid || o_frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: wr_valid=%0b frame_err=%0b addr=0x%0h, expected no event",
                   o_wr_valid, o_frame_err, o_wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("ev_frame_err", 32'(o_frame_err), 32'(e.is_err));
          check("ev_wr_valid", 32'(o_wr_valid), 32'(!e.is_err));
          if (!e.is_err) begin
            check("ev_wr_addr", 32'(o_wr_addr), 32'(e.addr));
            check("ev_wr_data", 32'(o_wr_data), 32'(e.data));
            check("ev_read_mode", 32'(o_read_mode), 32'(e.rmode));
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] rd;
    logic [7:0]  a;
    logic [15:0] d;
    int          n, sel;
    rst = 1'b1; sclk = 1'b0; sdata = 1'b0; sen = 1'b1;
    for (int i = 0; i < 128; i++) model_regs[i] = '0;
    tick(5);
    rst = 1'b0;
    tick(6);
    check("rst_wr_valid", 32'(o_wr_valid), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_read_mode", 32'(o_read_mode), 32'd0);
    check("rst_sdout", 32'(o_spi_sdout), 32'd0);

    send_frame({8'h10, 16'hA5C3}, 24, 1'b0);
    send_frame({8'h10, 16'h1234}, 13, 1'b0);
    send_frame({8'h10, 16'h4321}, 25, 1'b0);
    send_frame({8'h00, 16'h0002}, 24, 1'b0);
    send_frame({8'h10, 16'hFFFF}, 24, 1'b0);
    send_frame({8'h10, 16'h0000}, 24, 1'b0);
    send_frame({8'h90, 16'h0000}, 24, 1'b0);
    send_frame({8'h00, 16'h0000}, 24, 1'b0);
    send_frame({8'h90, 16'h5555}, 24, 1'b0);
    send_frame({8'h20, 16'hBEEF}, 24, 1'b1);

    // Reset mid-frame with SEN held low, then clock a full frame that must be ignored.
    sen = 1'b0;
    tick(4);
    clock_bits({8'h10, 16'h1111}, 10, rd);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) model_regs[i] = '0;
    tick(6);
    check("rst2_busy", 32'(o_busy), 32'd0);
    check("rst2_read_mode", 32'(o_read_mode), 32'd0);
    clock_bits({8'h10, 16'h2222}, 24, rd);
    check("held_sen_busy", 32'(o_busy), 32'd0);
    check("held_sen_sdout", 32'(rd), 32'd0);
    sen = 1'b1;
    tick(8);
    drain();
    send_frame({8'h10, 16'h3333}, 24, 1'b0);

    for (int f = 0; f < 36; f++) begin
      sel = int'($urandom_range(0, 3));
      d   = 16'($urandom);
      case (sel)
        0:       a = 8'h00;
        1:       a = 8'h10;
        2:       a = 8'($urandom);
        default: a = 8'($urandom_range(0, 127));
      endcase
      n = 24;
      if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 23)) : 25;
      send_frame({a, d}, n, 1'($urandom_range(0, 5) == 0));
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
